// File: rtl/top_ting_pkg.sv
// Shared definitions for the top_ting elliptic-curve scalar multiplier.
// Holds the datapath width, the operand load length in nibbles, the top-level
// FSM state enum, the field ALU opcode and state enums, the micro-op encoding
// used by the point-operation sequencer, and small modular-arithmetic helpers.
package top_ting_pkg;

  localparam int WIDTH   = 32;
  localparam int NIBBLES = 8;
  localparam logic [WIDTH-1:0] ONE = 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SCAN, ST_DBL, ST_ADD, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB, OP_INV} op_e;
  typedef enum logic [1:0] {ALU_IDLE, ALU_MUL, ALU_INV} alu_state_e;

  // Operand sources and destinations of one field operation in a point op.
  typedef enum logic [2:0] {SRC_X, SRC_Y, SRC_PX, SRC_PY, SRC_T1, SRC_T2, SRC_LAM, SRC_A} src_e;
  typedef enum logic [1:0] {DST_T1, DST_T2, DST_LAM} dst_e;

  typedef struct packed {
    op_e  op;
    src_e sa;
    src_e sb;
    dst_e dst;
    logic last;   // final step: T1 holds x3 and the ALU result is y3
  } uop_t;

  function automatic uop_t mk(input op_e o, input src_e sa, input src_e sb,
                              input dst_e d, input logic l);
    uop_t u;
    u.op = o; u.sa = sa; u.sb = sb; u.dst = d; u.last = l;
    return u;
  endfunction

  // R = 2R: lambda = (3x^2 + a) / 2y, x3 = lambda^2 - 2x, y3 = lambda(x - x3) - y
  function automatic uop_t dbl_uop(input logic [3:0] step);
    case (step)
      4'd0:    return mk(OP_MUL, SRC_X,   SRC_X,   DST_T1,  1'b0);
      4'd1:    return mk(OP_ADD, SRC_T1,  SRC_T1,  DST_T2,  1'b0);
      4'd2:    return mk(OP_ADD, SRC_T2,  SRC_T1,  DST_T1,  1'b0);
      4'd3:    return mk(OP_ADD, SRC_T1,  SRC_A,   DST_T1,  1'b0);
      4'd4:    return mk(OP_ADD, SRC_Y,   SRC_Y,   DST_T2,  1'b0);
      4'd5:    return mk(OP_INV, SRC_T2,  SRC_T2,  DST_T2,  1'b0);
      4'd6:    return mk(OP_MUL, SRC_T1,  SRC_T2,  DST_LAM, 1'b0);
      4'd7:    return mk(OP_MUL, SRC_LAM, SRC_LAM, DST_T1,  1'b0);
      4'd8:    return mk(OP_SUB, SRC_T1,  SRC_X,   DST_T1,  1'b0);
      4'd9:    return mk(OP_SUB, SRC_T1,  SRC_X,   DST_T1,  1'b0);
      4'd10:   return mk(OP_SUB, SRC_X,   SRC_T1,  DST_T2,  1'b0);
      4'd11:   return mk(OP_MUL, SRC_LAM, SRC_T2,  DST_T2,  1'b0);
      default: return mk(OP_SUB, SRC_T2,  SRC_Y,   DST_T2,  1'b1);
    endcase
  endfunction

  // R = R + P: lambda = (py - y) / (px - x), x3 = lambda^2 - x - px, y3 = lambda(x - x3) - y
  function automatic uop_t add_uop(input logic [3:0] step);
    case (step)
      4'd0:    return mk(OP_SUB, SRC_PY,  SRC_Y,   DST_T1,  1'b0);
      4'd1:    return mk(OP_SUB, SRC_PX,  SRC_X,   DST_T2,  1'b0);
      4'd2:    return mk(OP_INV, SRC_T2,  SRC_T2,  DST_T2,  1'b0);
      4'd3:    return mk(OP_MUL, SRC_T1,  SRC_T2,  DST_LAM, 1'b0);
      4'd4:    return mk(OP_MUL, SRC_LAM, SRC_LAM, DST_T1,  1'b0);
      4'd5:    return mk(OP_SUB, SRC_T1,  SRC_X,   DST_T1,  1'b0);
      4'd6:    return mk(OP_SUB, SRC_T1,  SRC_PX,  DST_T1,  1'b0);
      4'd7:    return mk(OP_SUB, SRC_X,   SRC_T1,  DST_T2,  1'b0);
      4'd8:    return mk(OP_MUL, SRC_LAM, SRC_T2,  DST_T2,  1'b0);
      default: return mk(OP_SUB, SRC_T2,  SRC_Y,   DST_T2,  1'b1);
    endcase
  endfunction

  // Operands are already reduced, so one conditional correction suffices.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] p);
    return (x >= y) ? (x - y) : (x - y + p);
  endfunction

  // x/2 mod p for odd p: add p first when x is odd so the shift is exact.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

endpackage

// File: rtl/ecc_field_alu.sv
// Modular arithmetic unit over GF(p): multiply, add, subtract, inverse.
// Ports: clk/rst (async active-high), start + op + opa/opb/prime request,
// done + result response.
// Handshake: start is a one-cycle request honoured only while the unit is
// idle; operands are captured on that edge. done pulses for exactly one cycle
// with result valid alongside it, and result holds until the next done.
// ADD/SUB answer one cycle after start, MUL after 32 shift-add steps,
// INV after at most 64 binary extended-Euclid steps. INV of 0 returns 0.
module ecc_field_alu
  import top_ting_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] prime,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, ma_q, ma_d, mb_q, mb_d, p_q, p_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, res_q, res_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mul_next;

  // MSB-first interleaved multiply: acc = 2*acc + (b[i] ? a : 0), reduced each step.
  assign mul_next = mod_add(mod_add(acc_q, acc_q, p_q), mb_q[cnt_q[4:0]] ? ma_q : '0, p_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ALU_IDLE;
      acc_q <= '0; ma_q <= '0; mb_q <= '0; p_q <= '0;
      u_q <= '0; v_q <= '0; x1_q <= '0; x2_q <= '0; res_q <= '0;
      cnt_q <= '0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d; ma_q <= ma_d; mb_q <= mb_d; p_q <= p_d;
      u_q <= u_d; v_q <= v_d; x1_q <= x1_d; x2_q <= x2_d; res_q <= res_d;
      cnt_q <= cnt_d; done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d = acc_q; ma_d = ma_q; mb_d = mb_q; p_d = p_q;
    u_d = u_q; v_d = v_q; x1_d = x1_q; x2_d = x2_q; res_d = res_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    case (state_q)
      ALU_IDLE: begin
        if (start) begin
          p_d = prime;
          case (op_e'(op))
            OP_ADD: begin res_d = mod_add(opa, opb, prime); done_d = 1'b1; end
            OP_SUB: begin res_d = mod_sub(opa, opb, prime); done_d = 1'b1; end
            OP_MUL: begin
              ma_d = opa; mb_d = opb; acc_d = '0; cnt_d = 7'd31;
              state_d = ALU_MUL;
            end
            default: begin
              if (opa == '0) begin
                res_d = '0; done_d = 1'b1;
              end else begin
                u_d = opa; v_d = prime; x1_d = ONE; x2_d = '0; cnt_d = '0;
                state_d = ALU_INV;
              end
            end
          endcase
        end
      end
      ALU_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd0) begin
          res_d = mul_next; done_d = 1'b1; state_d = ALU_IDLE;
        end
      end
      ALU_INV: begin
        // Invariants: x1*a == u and x2*a == v (mod p). Every step halves
        // u or v, so the loop ends once either reaches 1.
        if (u_q == ONE) begin
          res_d = x1_q; done_d = 1'b1; state_d = ALU_IDLE;
        end else if (v_q == ONE) begin
          res_d = x2_q; done_d = 1'b1; state_d = ALU_IDLE;
        end else if (u_q == '0 || v_q == '0 || cnt_q == 7'd127) begin
          res_d = '0; done_d = 1'b1; state_d = ALU_IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
          if (!u_q[0]) begin
            u_d = u_q >> 1; x1_d = mod_half(x1_q, p_q);
          end else if (!v_q[0]) begin
            v_d = v_q >> 1; x2_d = mod_half(x2_q, p_q);
          end else if (u_q >= v_q) begin
            u_d = (u_q - v_q) >> 1; x1_d = mod_half(mod_sub(x1_q, x2_q, p_q), p_q);
          end else begin
            v_d = (v_q - u_q) >> 1; x2_d = mod_half(mod_sub(x2_q, x1_q, p_q), p_q);
          end
        end
      end
      default: state_d = ALU_IDLE;
    endcase
  end

  assign done   = done_q;
  assign result = res_q;

endmodule

// File: rtl/top_ting.sv
// Elliptic-curve scalar multiplier k*P on y^2 = x^3 + a*x + b mod p.
// Inputs: i_clk, i_rst (async active-high), i_start pulse, then eight nibbles
// MSB first on a, prime, k, Px, Py. Outputs: kPx/kPy live accumulator R,
// final_output_1/2 registered result, final_done one-cycle pulse, raw1 = k.
// Left-to-right double-and-add; each point op is a fixed micro-op sequence
// run on ecc_field_alu. The point at infinity is a flag and reads out as (0,0).
module top_ting
  import top_ting_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       a,
  input  logic [3:0]       prime,
  input  logic [3:0]       k,
  input  logic [3:0]       Px,
  input  logic [3:0]       Py,
  output logic [WIDTH-1:0] kPx,
  output logic [WIDTH-1:0] kPy,
  output logic [WIDTH-1:0] final_output_1,
  output logic [WIDTH-1:0] final_output_2,
  output logic             final_done,
  output logic [WIDTH-1:0] raw1
);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [3:0]       step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d, p_q, p_d, k_q, k_d, px_q, px_d, py_q, py_d;
  logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d, t1_q, t1_d, t2_q, t2_d, lam_q, lam_d;
  logic [WIDTH-1:0] fo1_q, fo1_d, fo2_q, fo2_d;
  logic             r_inf_q, r_inf_d, found_q, found_d, issued_q, issued_d;
  logic             via_add_q, via_add_d, fdone_q, fdone_d;
  uop_t             uop;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_start, alu_done, end_bit, dbl_fin;

  assign uop = (state_q == ST_ADD) ? add_uop(step_q) : dbl_uop(step_q);

  ecc_field_alu u_alu (
    .clk(i_clk), .rst(i_rst), .start(alu_start), .op(uop.op),
    .opa(alu_a), .opb(alu_b), .prime(p_q), .done(alu_done), .result(alu_result)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE; cnt_q <= '0; bit_q <= '0; step_q <= '0;
      a_q <= '0; p_q <= '0; k_q <= '0; px_q <= '0; py_q <= '0;
      rx_q <= '0; ry_q <= '0; t1_q <= '0; t2_q <= '0; lam_q <= '0;
      fo1_q <= '0; fo2_q <= '0;
      r_inf_q <= 1'b0; found_q <= 1'b0; issued_q <= 1'b0; via_add_q <= 1'b0; fdone_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; bit_q <= bit_d; step_q <= step_d;
      a_q <= a_d; p_q <= p_d; k_q <= k_d; px_q <= px_d; py_q <= py_d;
      rx_q <= rx_d; ry_q <= ry_d; t1_q <= t1_d; t2_q <= t2_d; lam_q <= lam_d;
      fo1_q <= fo1_d; fo2_q <= fo2_d;
      r_inf_q <= r_inf_d; found_q <= found_d; issued_q <= issued_d;
      via_add_q <= via_add_d; fdone_q <= fdone_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; bit_d = bit_q; step_d = step_q;
    a_d = a_q; p_d = p_q; k_d = k_q; px_d = px_q; py_d = py_q;
    rx_d = rx_q; ry_d = ry_q; t1_d = t1_q; t2_d = t2_q; lam_d = lam_q;
    fo1_d = fo1_q; fo2_d = fo2_q;
    r_inf_d = r_inf_q; found_d = found_q; issued_d = issued_q; via_add_d = via_add_q;
    fdone_d = 1'b0; alu_start = 1'b0; end_bit = 1'b0; dbl_fin = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) begin state_d = ST_LOAD; cnt_d = '0; end
      ST_LOAD: begin
        a_d = {a_q[WIDTH-5:0], a};     p_d = {p_q[WIDTH-5:0], prime};
        k_d = {k_q[WIDTH-5:0], k};     px_d = {px_q[WIDTH-5:0], Px};
        py_d = {py_q[WIDTH-5:0], Py};  cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(NIBBLES - 1)) begin
          state_d = ST_SCAN; bit_d = 5'd31; found_d = 1'b0;
          r_inf_d = 1'b1; rx_d = '0; ry_d = '0; via_add_d = 1'b0;
        end
      end
      ST_SCAN: begin
        // Before the top set bit is found, walk down one bit per cycle;
        // that bit seeds R = P and every later bit costs a double (+ add).
        if (found_q) begin
          state_d = ST_DBL; step_d = '0; issued_d = 1'b0;
        end else begin
          if (k_q[bit_q]) begin
            found_d = 1'b1; r_inf_d = 1'b0; rx_d = px_q; ry_d = py_q;
          end
          end_bit = 1'b1;
        end
      end
      ST_DBL: begin
        if (!issued_q) begin
          if (step_q == 4'd0 && (r_inf_q || ry_q == '0)) begin
            r_inf_d = 1'b1; dbl_fin = 1'b1;
          end else begin
            alu_start = 1'b1; issued_d = 1'b1;
          end
        end else if (alu_done) begin
          issued_d = 1'b0;
          if (uop.last) begin
            rx_d = t1_q; ry_d = alu_result; dbl_fin = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            case (uop.dst)
              DST_T1:  t1_d = alu_result;
              DST_T2:  t2_d = alu_result;
              default: lam_d = alu_result;
            endcase
          end
        end
      end
      ST_ADD: begin
        if (!issued_q) begin
          if (step_q == 4'd0 && r_inf_q) begin
            r_inf_d = 1'b0; rx_d = px_q; ry_d = py_q; end_bit = 1'b1;
          end else if (step_q == 4'd0 && rx_q == px_q) begin
            // Equal x: either R == P (use doubling) or R == -P (infinity).
            if (ry_q == py_q) begin
              via_add_d = 1'b1; state_d = ST_DBL; step_d = '0;
            end else begin
              r_inf_d = 1'b1; end_bit = 1'b1;
            end
          end else begin
            alu_start = 1'b1; issued_d = 1'b1;
          end
        end else if (alu_done) begin
          issued_d = 1'b0;
          if (uop.last) begin
            rx_d = t1_q; ry_d = alu_result; end_bit = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            case (uop.dst)
              DST_T1:  t1_d = alu_result;
              DST_T2:  t2_d = alu_result;
              default: lam_d = alu_result;
            endcase
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A doubling that stood in for P+P finishes the bit; otherwise the
    // current bit decides whether an add follows.
    if (dbl_fin) begin
      if (via_add_q) begin
        via_add_d = 1'b0; end_bit = 1'b1;
      end else if (k_q[bit_q]) begin
        state_d = ST_ADD; step_d = '0; issued_d = 1'b0;
      end else begin
        end_bit = 1'b1;
      end
    end
    if (end_bit) begin
      if (bit_q == 5'd0) state_d = ST_DONE;
      else begin bit_d = bit_q - 5'd1; state_d = ST_SCAN; end
    end

    // Result registers load on the same edge that raises final_done.
    if (state_d == ST_DONE) begin
      fdone_d = 1'b1;
      fo1_d = r_inf_d ? '0 : rx_d;
      fo2_d = r_inf_d ? '0 : ry_d;
    end
  end

  // Outputs and ALU operand selection.
  always_comb begin
    kPx = rx_q; kPy = ry_q; raw1 = k_q;
    final_output_1 = fo1_q; final_output_2 = fo2_q; final_done = fdone_q;
    alu_a = '0; alu_b = '0;
    case (uop.sa)
      SRC_X: alu_a = rx_q;   SRC_Y: alu_a = ry_q;   SRC_PX: alu_a = px_q; SRC_PY: alu_a = py_q;
      SRC_T1: alu_a = t1_q;  SRC_T2: alu_a = t2_q;  SRC_LAM: alu_a = lam_q; default: alu_a = a_q;
    endcase
    case (uop.sb)
      SRC_X: alu_b = rx_q;   SRC_Y: alu_b = ry_q;   SRC_PX: alu_b = px_q; SRC_PY: alu_b = py_q;
      SRC_T1: alu_b = t1_q;  SRC_T2: alu_b = t2_q;  SRC_LAM: alu_b = lam_q; default: alu_b = a_q;
    endcase
  end

endmodule

// File: tb/tb_top_ting.sv
// Bench for top_ting on the curve a=2, p=17, P=(5,1) (group order 19).
// Expected points come from a table of the 19 multiples of P.
module tb_top_ting;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [3:0]  a = '0, prime = '0, k = '0, Px = '0, Py = '0;
  logic [31:0] kPx, kPy, final_output_1, final_output_2, raw1;
  logic        final_done;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mult_tab[19];
  logic [31:0] cur_a = 32'd2, cur_p = 32'd17, cur_px = 32'd5, cur_py = 32'd1;

  top_ting dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .a(a), .prime(prime), .k(k), .Px(Px), .Py(Py),
    .kPx(kPx), .kPy(kPy), .final_output_1(final_output_1),
    .final_output_2(final_output_2), .final_done(final_done), .raw1(raw1)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic randomize_nibbles();
    a = 4'($urandom_range(0, 15)); prime = 4'($urandom_range(0, 15));
    k = 4'($urandom_range(0, 15)); Px = 4'($urandom_range(0, 15));
    Py = 4'($urandom_range(0, 15));
  endtask

  // Driver: start pulse (no data) then eight nibbles MSB first.
  task automatic drive_load(input logic [31:0] kv, input bit noisy);
    @(negedge i_clk);
    i_start = 1'b1;
    randomize_nibbles();
    for (int n = 7; n >= 0; n--) begin
      @(negedge i_clk);
      i_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      a = cur_a[n*4 +: 4]; prime = cur_p[n*4 +: 4]; k = kv[n*4 +: 4];
      Px = cur_px[n*4 +: 4]; Py = cur_py[n*4 +: 4];
    end
  endtask

  // One full computation: push expectation, load, wait for final_done,
  // pop and compare, then check pulse width and output hold.
  task automatic run_case(input logic [31:0] kv, input bit noisy);
    logic [63:0] expv, got;
    time         t0;
    int          lat, idx;
    bit          seen;
    idx = int'(kv % 32'd19);
    exp_q.push_back(mult_tab[idx]);
    t0 = $time + 5;
    drive_load(kv, noisy);
    seen = 1'b0;
    lat = 0;
    for (int c = 0; c < 14000 && !seen; c++) begin
      @(negedge i_clk);
      if (final_done) begin
        seen = 1'b1;
        i_start = 1'b0;
        lat = int'(($time - t0) / 10);
      end else begin
        if (noisy) i_start = 1'($urandom_range(0, 1));
        randomize_nibbles();
      end
    end
    i_start = 1'b0;
    expv = exp_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout k=%0d: final_done not seen within 14000 cycles, required a pulse", kv);
      apply_reset();
    end else begin
      got = {final_output_1, final_output_2};
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL result k=%0d: got (%0d,%0d) required (%0d,%0d)", kv,
                 got[63:32], got[31:0], expv[63:32], expv[31:0]);
      end
      n_checks++;
      if (raw1 !== kv) begin
        n_fail++;
        $display("FAIL raw1 k=%0d: got %0d required %0d", kv, raw1, kv);
      end
      n_checks++;
      if (lat > 14000) begin
        n_fail++;
        $display("FAIL latency k=%0d: got %0d cycles required <= 14000", kv, lat);
      end
      @(negedge i_clk);
      n_checks++;
      if (final_done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_width k=%0d: final_done got %b one cycle later, required 0", kv, final_done);
      end
      repeat (3) @(negedge i_clk);
      n_checks++;
      if ({final_output_1, final_output_2} !== expv || final_done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold k=%0d: got (%0d,%0d) done=%b required (%0d,%0d) done=0", kv,
                 final_output_1, final_output_2, final_done, expv[63:32], expv[31:0]);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    n_checks++;
    if ({kPx, kPy, final_output_1, final_output_2, raw1} !== '0 || final_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: outputs kPx=%0d kPy=%0d fo1=%0d fo2=%0d raw1=%0d done=%b required all 0",
               tag, kPx, kPy, final_output_1, final_output_2, raw1, final_done);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #1;
    check_cleared("reset_state");
    repeat (2) @(negedge i_clk);
    check_cleared("reset_held");
    i_rst = 1'b0;
  endtask

  task automatic test_known_vectors();
    logic [31:0] ks[10] = '{32'd1, 32'd2, 32'd9, 32'd18, 32'd19, 32'd0, 32'd3, 32'd21, 32'd38, 32'd255};
    foreach (ks[i]) run_case(ks[i], 1'b0);
  endtask

  task automatic test_mid_reset();
    drive_load(32'd9, 1'b0);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (300) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_cleared("mid_reset");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    run_case(32'd4, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] kv;
    for (int i = 0; i < 4; i++) begin
      kv = (i < 2) ? ((i == 0) ? 32'd5 : 32'd13) : 32'($urandom_range(1, 255));
      run_case(kv, 1'b1);
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1 check_cleared("b2b_reset");
      @(negedge i_clk);
      i_rst = 1'b0;
    end
  endtask

  initial begin
    mult_tab = '{{32'd0, 32'd0},  {32'd5, 32'd1},   {32'd6, 32'd3},   {32'd10, 32'd6},
                 {32'd3, 32'd1},  {32'd9, 32'd16},  {32'd16, 32'd13}, {32'd0, 32'd6},
                 {32'd13, 32'd7}, {32'd7, 32'd6},   {32'd7, 32'd11},  {32'd13, 32'd10},
                 {32'd0, 32'd11}, {32'd16, 32'd4},  {32'd9, 32'd1},   {32'd3, 32'd16},
                 {32'd10, 32'd11}, {32'd6, 32'd14}, {32'd5, 32'd16}};
    test_reset();
    test_known_vectors();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
